tapasco_dmi_ctrl: RTL and testbench
===================================

// Module: tapasco_dmi_ctrl
// PURPOSE
// Sequences host-side DMI register accesses into the dm_top DMI valid/ready request/response handshake.
// Converts a level host request into exactly one DMI transaction per rising edge.
// Retries BUSY responses, enforces a timeout and holds read data and status stable for the host.
// Sits between the TaPaSCo register interface and dm_top's dmi_req_*/dmi_resp_* ports.
// PARAMETERS
// MAX_RETRY       3     BUSY (resp=2'b11) retries before giving up; 0 = no retry
// BACKOFF_CYCLES  4     idle cycles in BACKOFF before reissuing; >=1
// TIMEOUT_CYCLES  1024  max cycles spent in REQ+RESP per attempt; 0 = timeout disabled
// PORTS
// clk_i             in   1   clock
// rst_i             in   1   asynchronous reset, active-high
// host_req_i        in   1   level request; rising edge starts an access
// host_wr_i         in   1   1 = write, 0 = read; sampled on the start edge
// host_addr_i       in   7   DMI address; sampled on the start edge
// host_wdata_i      in   32  write data; sampled on the start edge
// host_busy_o       out  1   access in flight (any state except IDLE)
// host_done_o       out  1   1-cycle pulse when an access completes
// host_rdata_o      out  32  last read data; held until the next completed read
// host_status_o     out  2   0 OK, 1 TIMEOUT, 2 FAILED (resp=2'b10), 3 BUSY_EXHAUSTED
// host_overrun_o    out  1   sticky: a start edge was dropped while busy; cleared by the next accepted start
// dmi_req_valid_o   out  1   DMI request valid
// dmi_req_ready_i   in   1   DMI request ready
// dmi_req_o         out  41  dm::dmi_req_t {addr, op, data}; op = DTM_WRITE/DTM_READ, DTM_NOP when not valid
// dmi_resp_valid_i  in   1   DMI response valid
// dmi_resp_ready_o  out  1   DMI response ready
// dmi_resp_i        in   34  dm::dmi_resp_t {data, resp}
// BEHAVIOUR
// - Reset: state=IDLE; all outputs 0; dmi_req_o.op=DTM_NOP; counters 0; captured req_q, edge flop 0.
// - Start: start = host_req_i & ~host_req_q (registered edge detect).
//   - In IDLE: capture wr/addr/wdata, clear the retry count, clear host_overrun_o, go to REQ next cycle.
//   - Otherwise: set host_overrun_o; the start is ignored.
// - REQ: dmi_req_valid_o=1; dmi_req_o held stable until dmi_req_valid_o & dmi_req_ready_i, then RESP.
// - RESP: dmi_resp_ready_o=1; on dmi_resp_valid_i:
//   - resp=2'b11 and retry<MAX_RETRY: retry++ and go to BACKOFF.
//   - Otherwise go to DONE, latching status. Read with resp=0: host_rdata_o <= dmi_resp_i.data.
//   - Writes and errored reads leave host_rdata_o unchanged.
// - BACKOFF: count BACKOFF_CYCLES cycles, then REQ (same captured request); the timeout counter restarts.
// - DONE: host_done_o=1 for exactly one cycle, then IDLE. Latency: start edge -> dmi_req_valid_o = 1 cycle.
//   With ready=1 and a response 1 cycle after the handshake, host_done_o comes 3 cycles after dmi_req_valid_o rises.
// - Timeout: timeout counter runs in REQ and RESP.
//   - On reaching TIMEOUT_CYCLES: go to DONE with status=1; dmi_req_valid_o drops (abort).
//   - host_rdata_o is unchanged on timeout.
// - Stray responses: dmi_resp_ready_o is also 1 in IDLE, so late responses after a timeout are drained and discarded.
// - Simultaneous events: response and timeout in the same cycle -> the response wins.
//   Start edge in the DONE cycle -> counts as overrun (not accepted).
// - Counters saturate; widths are $clog2(param+1); no wrap.
// - Reset mid-access: immediate return to IDLE; the DMI handshake is abandoned (dm_top shares the reset).
// STRUCTURE
// - Add package tapasco_dmi_pkg:
//   - state enum {IDLE, REQ, RESP, BACKOFF, DONE}
//   - status enum {ST_OK, ST_TIMEOUT, ST_FAILED, ST_BUSY_EXH}
//   - DMI resp constants RESP_OK=2'b00, RESP_FAILED=2'b10, RESP_BUSY=2'b11
// - Reuse dm::dmi_req_t, dm::dmi_resp_t and dm::dtm_op_e.
// - Single flat module; no sub-module needed (counters are inline).
// TESTING
// 1. Read addr 7'h11 with ready=1 and a resp of {data=32'hDEAD_BEEF, resp=0} 1 cycle later
//    -> exactly 1 req handshake, op=DTM_READ, done pulse, rdata=DEADBEEF, status=0.
// 2. Hold host_req_i high for 50 cycles -> exactly one DMI request; a second rising edge after done -> a second request.
// 3. Write responses BUSY,BUSY,OK with MAX_RETRY=3 -> 3 handshakes with identical payload,
//    >=BACKOFF_CYCLES gap between them, status=0, rdata unchanged.
// 4. BUSY returned 4 times with MAX_RETRY=3 -> 4 handshakes, status=3; resp=2'b10 -> status=2, no retry.
// 5. dmi_req_ready_i stuck 0 with TIMEOUT_CYCLES=16 -> valid drops after 16 cycles, done pulse, status=1;
//    a late response while IDLE is drained and rdata is unchanged.
// 6. Start edge while busy -> overrun=1, no extra request; rst_i asserted mid-RESP -> all outputs 0 next edge, state IDLE.

Source files
------------

// File: rtl/dm_pkg.sv
// Debug-module DMI types shared by the debug transport and this controller.
// Mirrors the dm_top request/response layout: {addr, op, data} and {data, resp}.
package dm;

    typedef enum logic [1:0] {
        DTM_NOP   = 2'h0,
        DTM_READ  = 2'h1,
        DTM_WRITE = 2'h2
    } dtm_op_e;

    typedef struct packed {
        logic [6:0]  addr;
        dtm_op_e     op;
        logic [31:0] data;
    } dmi_req_t;

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  resp;
    } dmi_resp_t;

endpackage

// File: rtl/tapasco_dmi_pkg.sv
// Shared types and helpers for the TaPaSCo-side DMI access sequencer.
// Holds the controller state encoding, host status codes and DMI response codes.
package tapasco_dmi_pkg;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        RESP,
        BACKOFF,
        DONE
    } state_t;

    typedef enum logic [1:0] {
        ST_OK       = 2'd0,
        ST_TIMEOUT  = 2'd1,
        ST_FAILED   = 2'd2,
        ST_BUSY_EXH = 2'd3
    } status_t;

    localparam logic [1:0] RESP_OK     = 2'b00;
    localparam logic [1:0] RESP_FAILED = 2'b10;
    localparam logic [1:0] RESP_BUSY   = 2'b11;

    // Counter width able to hold 0..n, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n == 0) ? 1 : $clog2(n + 1);
    endfunction

    // Final host status for a response that ends the access; the reserved code is reported as a failure.
    function automatic status_t resp_to_status(input logic [1:0] resp);
        status_t st;
        case (resp)
            RESP_OK:   st = ST_OK;
            RESP_BUSY: st = ST_BUSY_EXH;
            default:   st = ST_FAILED;
        endcase
        return st;
    endfunction

endpackage

// File: rtl/tapasco_dmi_ctrl.sv
// Turns a level host register request into one dm_top DMI valid/ready transaction,
// retrying BUSY responses with a backoff and aborting attempts that exceed the timeout.
module tapasco_dmi_ctrl
    import tapasco_dmi_pkg::*;
#(
    parameter int unsigned MAX_RETRY      = 3,
    parameter int unsigned BACKOFF_CYCLES = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          host_req_i,
    input  logic          host_wr_i,
    input  logic [6:0]    host_addr_i,
    input  logic [31:0]   host_wdata_i,
    output logic          host_busy_o,
    output logic          host_done_o,
    output logic [31:0]   host_rdata_o,
    output logic [1:0]    host_status_o,
    output logic          host_overrun_o,
    output logic          dmi_req_valid_o,
    input  logic          dmi_req_ready_i,
    output dm::dmi_req_t  dmi_req_o,
    input  logic          dmi_resp_valid_i,
    output logic          dmi_resp_ready_o,
    input  dm::dmi_resp_t dmi_resp_i
);

    localparam int unsigned RETRY_W  = cnt_width(MAX_RETRY);
    localparam int unsigned BO_W     = cnt_width(BACKOFF_CYCLES);
    localparam int unsigned TO_W     = cnt_width(TIMEOUT_CYCLES);
    localparam int unsigned BO_LIMIT = (BACKOFF_CYCLES == 0) ? 0 : BACKOFF_CYCLES - 1;
    localparam int unsigned TO_LIMIT = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;

    state_t               state_q, state_d;
    status_t              status_q, status_d;
    logic                 host_req_q;
    logic                 start;
    logic                 wr_q;
    logic [6:0]           addr_q;
    logic [31:0]          wdata_q;
    logic [31:0]          rdata_q, rdata_d;
    logic [RETRY_W-1:0]   retry_q, retry_d;
    logic [BO_W-1:0]      bo_cnt_q;
    logic [TO_W-1:0]      to_cnt_q;
    logic                 overrun_q;
    logic                 timeout_hit;
    logic                 bo_done;
    logic                 in_flight;

    assign start       = host_req_i & ~host_req_q;
    assign in_flight   = (state_q == REQ) || (state_q == RESP);
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (to_cnt_q >= TO_W'(TO_LIMIT));
    assign bo_done     = (bo_cnt_q == BO_W'(BO_LIMIT));

    // A handshake or response in the timeout cycle wins, so accepted traffic is never abandoned.
    always_comb begin
        state_d  = state_q;
        status_d = status_q;
        rdata_d  = rdata_q;
        retry_d  = retry_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    retry_d = '0;
                    state_d = REQ;
                end
            end
            REQ: begin
                if (dmi_req_ready_i) begin
                    state_d = RESP;
                end else if (timeout_hit) begin
                    status_d = ST_TIMEOUT;
                    state_d  = DONE;
                end
            end
            RESP: begin
                if (dmi_resp_valid_i) begin
                    if (dmi_resp_i.resp == RESP_BUSY && retry_q < RETRY_W'(MAX_RETRY)) begin
                        retry_d = retry_q + RETRY_W'(1);
                        state_d = BACKOFF;
                    end else begin
                        status_d = resp_to_status(dmi_resp_i.resp);
                        if (!wr_q && dmi_resp_i.resp == RESP_OK) begin
                            rdata_d = dmi_resp_i.data;
                        end
                        state_d = DONE;
                    end
                end else if (timeout_hit) begin
                    status_d = ST_TIMEOUT;
                    state_d  = DONE;
                end
            end
            BACKOFF: begin
                if (bo_done) begin
                    state_d = REQ;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            status_q   <= ST_OK;
            host_req_q <= 1'b0;
            wr_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            retry_q    <= '0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            status_q   <= status_d;
            rdata_q    <= rdata_d;
            retry_q    <= retry_d;
            host_req_q <= host_req_i;
            if (start && state_q == IDLE) begin
                wr_q    <= host_wr_i;
                addr_q  <= host_addr_i;
                wdata_q <= host_wdata_i;
            end
            // Start edges seen outside IDLE (including the DONE cycle) are dropped and flagged.
            if (start) begin
                overrun_q <= (state_q != IDLE);
            end
        end
    end

    // Timeout budget is per attempt: it restarts whenever REQ is re-entered from IDLE or BACKOFF.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            bo_cnt_q <= '0;
            to_cnt_q <= '0;
        end else begin
            if (state_q == BACKOFF) begin
                bo_cnt_q <= bo_done ? '0 : bo_cnt_q + BO_W'(1);
            end else begin
                bo_cnt_q <= '0;
            end
            if (in_flight) begin
                to_cnt_q <= (to_cnt_q == TO_W'(TO_LIMIT)) ? to_cnt_q : to_cnt_q + TO_W'(1);
            end else begin
                to_cnt_q <= '0;
            end
        end
    end

    always_comb begin
        dmi_req_o.addr = addr_q;
        dmi_req_o.data = wdata_q;
        dmi_req_o.op   = dm::DTM_NOP;
        if (state_q == REQ) begin
            dmi_req_o.op = wr_q ? dm::DTM_WRITE : dm::DTM_READ;
        end
    end

    // Responses are also accepted in IDLE so stragglers from an aborted attempt get drained.
    assign dmi_resp_ready_o = ((state_q == IDLE) || (state_q == RESP)) && !rst_i;
    assign dmi_req_valid_o  = (state_q == REQ);
    assign host_busy_o      = (state_q != IDLE);
    assign host_done_o      = (state_q == DONE);
    assign host_rdata_o     = rdata_q;
    assign host_status_o    = status_q;
    assign host_overrun_o   = overrun_q;

endmodule

// File: tb/tb_tapasco_dmi_ctrl.sv
// Self-checking bench for tapasco_dmi_ctrl: a scripted DMI responder plus an access-level
// reference model (attempt count, final status, read-data hold) driven by directed and random accesses.
module tb_tapasco_dmi_ctrl;
    import dm::*;

    localparam int MAX_RETRY = 3;
    localparam int BACKOFF   = 4;
    localparam int TIMEOUT   = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        host_req, host_wr;
    logic [6:0]  host_addr;
    logic [31:0] host_wdata;
    logic        host_busy, host_done, host_overrun;
    logic [31:0] host_rdata;
    logic [1:0]  host_status;
    logic        dmi_req_valid, dmi_req_ready;
    dmi_req_t    dmi_req;
    logic        dmi_resp_valid, dmi_resp_ready;
    dmi_resp_t   dmi_resp;

    int asserts  = 0;
    int failures = 0;
    int cyc      = 0;

    // Responder configuration and observation state
    int          ready_delay = 0;
    int          resp_lat    = 1;
    int          rdy_wait    = 0;
    int          countdown   = -1;
    logic [1:0]  rq[$];
    logic [31:0] dq[$];
    bit          prev_hs  = 1'b0;
    bit          prev_acc = 1'b0;
    dmi_req_t    hs_snap;
    int          hs_count = 0;
    dmi_req_t    hs_payload[$];
    int          hs_cyc[$];
    logic [31:0] exp_rdata = '0;

    tapasco_dmi_ctrl #(
        .MAX_RETRY      (MAX_RETRY),
        .BACKOFF_CYCLES (BACKOFF),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .host_req_i       (host_req),
        .host_wr_i        (host_wr),
        .host_addr_i      (host_addr),
        .host_wdata_i     (host_wdata),
        .host_busy_o      (host_busy),
        .host_done_o      (host_done),
        .host_rdata_o     (host_rdata),
        .host_status_o    (host_status),
        .host_overrun_o   (host_overrun),
        .dmi_req_valid_o  (dmi_req_valid),
        .dmi_req_ready_i  (dmi_req_ready),
        .dmi_req_o        (dmi_req),
        .dmi_resp_valid_i (dmi_resp_valid),
        .dmi_resp_ready_o (dmi_resp_ready),
        .dmi_resp_i       (dmi_resp)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // DMI slave model: works on negedges, resolving what happened at the preceding posedge.
    initial begin
        dmi_req_ready  = 1'b0;
        dmi_resp_valid = 1'b0;
        dmi_resp       = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                countdown      = -1;
                dmi_resp_valid = 1'b0;
                dmi_req_ready  = 1'b0;
                prev_hs        = 1'b0;
                prev_acc       = 1'b0;
                rdy_wait       = 0;
            end else begin
                if (prev_acc) dmi_resp_valid = 1'b0;
                if (countdown == 0) begin
                    if (rq.size() > 0) begin
                        dmi_resp.resp = rq.pop_front();
                        dmi_resp.data = dq.pop_front();
                    end else begin
                        dmi_resp = '0;
                    end
                    dmi_resp_valid = 1'b1;
                    countdown = -1;
                end else if (countdown > 0) begin
                    countdown--;
                end
                if (prev_hs) begin
                    hs_count++;
                    hs_payload.push_back(hs_snap);
                    hs_cyc.push_back(cyc);
                    countdown = resp_lat - 1;
                end
                if (dmi_req_valid) begin
                    if (rdy_wait >= ready_delay) dmi_req_ready = 1'b1;
                    else begin
                        dmi_req_ready = 1'b0;
                        rdy_wait++;
                    end
                end else begin
                    dmi_req_ready = 1'b0;
                    rdy_wait = 0;
                end
                prev_hs  = dmi_req_valid & dmi_req_ready;
                hs_snap  = dmi_req;
                prev_acc = dmi_resp_valid & dmi_resp_ready;
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got no end of test, expected finish before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_script();
        rq.delete();
        dq.delete();
        hs_count = 0;
        hs_payload.delete();
        hs_cyc.delete();
    endtask

    // Drives one host access and collects observations; starts and ends at posedge+1 with host_req low.
    task automatic do_access(input bit wr, input logic [6:0] addr, input logic [31:0] wdata,
                             input int hold, output int dones, output int t_valid,
                             output int t_done, output int vcycles, output bit timed_out);
        int i;
        bit fin;
        hs_count = 0;
        hs_payload.delete();
        hs_cyc.delete();
        host_wr    = wr;
        host_addr  = addr;
        host_wdata = wdata;
        host_req   = 1'b1;
        dones = 0; t_valid = -1; t_done = -1; vcycles = 0;
        i = 0; fin = 1'b0;
        while (!fin && i < 300) begin
            i++;
            tick();
            if (dmi_req_valid) begin
                vcycles++;
                if (t_valid < 0) t_valid = i;
            end
            if (host_done) begin
                dones++;
                if (t_done < 0) t_done = i;
            end
            if (i >= hold) host_req = 1'b0;
            if (t_done >= 0 && i >= t_done + 2 && i >= hold) fin = 1'b1;
        end
        host_req = 1'b0;
        tick();
        timed_out = (t_done < 0);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        host_req = 1'b0; host_wr = 1'b0; host_addr = '0; host_wdata = '0;
        tick(); tick();
        asserts++;
        if ({host_busy, host_done, host_overrun, dmi_req_valid, dmi_resp_ready} !== 5'b0) begin
            failures++;
            $display("[TB] FAIL reset_flags: got %b expected 00000",
                     {host_busy, host_done, host_overrun, dmi_req_valid, dmi_resp_ready});
        end
        asserts++;
        if (dmi_req !== 41'd0 || host_rdata !== 32'd0 || host_status !== 2'd0) begin
            failures++;
            $display("[TB] FAIL reset_data: got req=%h rdata=%h status=%0d expected all 0",
                     dmi_req, host_rdata, host_status);
        end
        rst = 1'b0;
        tick();
        asserts++;
        if (host_busy !== 1'b0 || dmi_resp_ready !== 1'b1) begin
            failures++;
            $display("[TB] FAIL idle_after_reset: got busy=%b resp_ready=%b expected 0 1",
                     host_busy, dmi_resp_ready);
        end
        exp_rdata = '0;
    endtask

    task automatic test_basic_read();
        int dn, tv, td, vc;
        bit to;
        clear_script();
        ready_delay = 0; resp_lat = 1;
        rq.push_back(2'b00); dq.push_back(32'hDEAD_BEEF);
        do_access(1'b0, 7'h11, $urandom, 1, dn, tv, td, vc, to);
        exp_rdata = 32'hDEAD_BEEF;
        asserts++;
        if (hs_count !== 1 || dn !== 1 || to) begin
            failures++;
            $display("[TB] FAIL read_counts: got hs=%0d done=%0d expected 1 1", hs_count, dn);
        end
        asserts++;
        if (hs_count > 0 && (hs_payload[0].op !== DTM_READ || hs_payload[0].addr !== 7'h11)) begin
            failures++;
            $display("[TB] FAIL read_payload: got op=%0d addr=%h expected op=1 addr=11",
                     hs_payload[0].op, hs_payload[0].addr);
        end
        asserts++;
        if (tv !== 1 || td - tv !== 3) begin
            failures++;
            $display("[TB] FAIL read_latency: got valid@%0d done-valid=%0d expected 1 and 3", tv, td - tv);
        end
        asserts++;
        if (host_rdata !== exp_rdata || host_status !== 2'd0 || host_busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL read_result: got rdata=%h status=%0d busy=%b expected %h 0 0",
                     host_rdata, host_status, host_busy, exp_rdata);
        end
    endtask

    task automatic test_level_hold();
        int dn, tv, td, vc;
        bit to;
        clear_script();
        rq.push_back(2'b00); dq.push_back(32'hCAFE_0001);
        rq.push_back(2'b00); dq.push_back(32'hCAFE_0002);
        do_access(1'b0, 7'h22, '0, 50, dn, tv, td, vc, to);
        asserts++;
        if (hs_count !== 1 || dn !== 1 || to) begin
            failures++;
            $display("[TB] FAIL level_hold: got hs=%0d done=%0d expected 1 1", hs_count, dn);
        end
        do_access(1'b0, 7'h23, '0, 1, dn, tv, td, vc, to);
        exp_rdata = 32'hCAFE_0002;
        asserts++;
        if (hs_count !== 1 || dn !== 1 || host_rdata !== exp_rdata) begin
            failures++;
            $display("[TB] FAIL second_edge: got hs=%0d done=%0d rdata=%h expected 1 1 %h",
                     hs_count, dn, host_rdata, exp_rdata);
        end
    endtask

    task automatic test_busy_retry();
        int dn, tv, td, vc;
        bit to, bad;
        logic [31:0] wd;
        clear_script();
        ready_delay = 1; resp_lat = 2;
        wd = $urandom;
        rq.push_back(2'b11); dq.push_back($urandom);
        rq.push_back(2'b11); dq.push_back($urandom);
        rq.push_back(2'b00); dq.push_back($urandom);
        do_access(1'b1, 7'h10, wd, 1, dn, tv, td, vc, to);
        asserts++;
        if (hs_count !== 3 || dn !== 1 || host_status !== 2'd0 || host_rdata !== exp_rdata) begin
            failures++;
            $display("[TB] FAIL busy_retry: got hs=%0d done=%0d status=%0d rdata=%h expected 3 1 0 %h",
                     hs_count, dn, host_status, host_rdata, exp_rdata);
        end
        bad = 1'b0;
        for (int k = 0; k < hs_payload.size(); k++) begin
            if (hs_payload[k].op !== DTM_WRITE || hs_payload[k].addr !== 7'h10 || hs_payload[k].data !== wd)
                bad = 1'b1;
            if (k > 0 && hs_cyc[k] - hs_cyc[k-1] <= BACKOFF) bad = 1'b1;
        end
        asserts++;
        if (bad) begin
            failures++;
            $display("[TB] FAIL retry_payload_gap: got inconsistent payload or gap, expected identical writes %h gap>%0d",
                     wd, BACKOFF);
        end
    endtask

    task automatic test_busy_exhausted();
        int dn, tv, td, vc;
        bit to;
        clear_script();
        ready_delay = 0; resp_lat = 1;
        for (int k = 0; k < 4; k++) begin
            rq.push_back(2'b11); dq.push_back($urandom);
        end
        do_access(1'b0, 7'h05, '0, 1, dn, tv, td, vc, to);
        asserts++;
        if (hs_count !== 4 || host_status !== 2'd3 || host_rdata !== exp_rdata || dn !== 1) begin
            failures++;
            $display("[TB] FAIL busy_exhausted: got hs=%0d status=%0d rdata=%h expected 4 3 %h",
                     hs_count, host_status, host_rdata, exp_rdata);
        end
        clear_script();
        rq.push_back(2'b10); dq.push_back(32'h0BAD_0BAD);
        rq.push_back(2'b00); dq.push_back(32'h1111_1111);
        do_access(1'b0, 7'h06, '0, 1, dn, tv, td, vc, to);
        asserts++;
        if (hs_count !== 1 || host_status !== 2'd2 || host_rdata !== exp_rdata || dn !== 1) begin
            failures++;
            $display("[TB] FAIL resp_failed: got hs=%0d status=%0d rdata=%h expected 1 2 %h",
                     hs_count, host_status, host_rdata, exp_rdata);
        end
    endtask

    task automatic test_timeout();
        int dn, tv, td, vc, extra_done;
        bit to;
        clear_script();
        ready_delay = 100000; resp_lat = 1;
        do_access(1'b0, 7'h33, '0, 1, dn, tv, td, vc, to);
        asserts++;
        if (vc !== TIMEOUT || td - tv !== TIMEOUT || dn !== 1 || hs_count !== 0) begin
            failures++;
            $display("[TB] FAIL timeout_abort: got valid_cycles=%0d done-valid=%0d done=%0d hs=%0d expected %0d %0d 1 0",
                     vc, td - tv, dn, hs_count, TIMEOUT, TIMEOUT);
        end
        asserts++;
        if (host_status !== 2'd1 || host_rdata !== exp_rdata) begin
            failures++;
            $display("[TB] FAIL timeout_status: got status=%0d rdata=%h expected 1 %h",
                     host_status, host_rdata, exp_rdata);
        end
        ready_delay = 0;
        rq.push_back(2'b00); dq.push_back(32'h5555_AAAA);
        countdown = 0;
        extra_done = 0;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (host_done || host_busy) extra_done++;
        end
        asserts++;
        if (rq.size() !== 0 || dmi_resp_valid !== 1'b0 || extra_done !== 0 || host_rdata !== exp_rdata) begin
            failures++;
            $display("[TB] FAIL stray_drain: got pending=%0d resp_valid=%b activity=%0d rdata=%h expected 0 0 0 %h",
                     rq.size(), dmi_resp_valid, extra_done, host_rdata, exp_rdata);
        end
    endtask

    task automatic test_overrun();
        int dn, tv, td, vc, n;
        bit to;
        clear_script();
        ready_delay = 0; resp_lat = 8;
        rq.push_back(2'b00); dq.push_back(32'h7777_0001);
        rq.push_back(2'b00); dq.push_back(32'h7777_0002);
        host_wr = 1'b0; host_addr = 7'h44; host_wdata = '0;
        hs_count = 0;
        host_req = 1'b1;
        tick(); tick();
        host_req = 1'b0;
        tick();
        host_req = 1'b1;
        tick(); tick();
        asserts++;
        if (host_overrun !== 1'b1 || host_busy !== 1'b1) begin
            failures++;
            $display("[TB] FAIL overrun_set: got overrun=%b busy=%b expected 1 1", host_overrun, host_busy);
        end
        n = 0;
        while (!host_done && n < 100) begin
            tick();
            n++;
        end
        host_req = 1'b0;
        tick(); tick(); tick();
        exp_rdata = 32'h7777_0001;
        asserts++;
        if (n >= 100 || hs_count !== 1 || host_overrun !== 1'b1 || host_rdata !== exp_rdata) begin
            failures++;
            $display("[TB] FAIL overrun_single: got wait=%0d hs=%0d overrun=%b rdata=%h expected <100 1 1 %h",
                     n, hs_count, host_overrun, host_rdata, exp_rdata);
        end
        resp_lat = 1;
        do_access(1'b0, 7'h45, '0, 1, dn, tv, td, vc, to);
        exp_rdata = 32'h7777_0002;
        asserts++;
        if (host_overrun !== 1'b0 || hs_count !== 1 || host_rdata !== exp_rdata) begin
            failures++;
            $display("[TB] FAIL overrun_clear: got overrun=%b hs=%0d rdata=%h expected 0 1 %h",
                     host_overrun, hs_count, host_rdata, exp_rdata);
        end
    endtask

    task automatic test_reset_mid();
        int n;
        clear_script();
        ready_delay = 0; resp_lat = 12;
        rq.push_back(2'b00); dq.push_back(32'h9999_9999);
        host_wr = 1'b1; host_addr = 7'h55; host_wdata = 32'h1234_5678;
        host_req = 1'b1;
        n = 0;
        while (hs_count == 0 && n < 20) begin
            tick();
            n++;
        end
        tick();
        asserts++;
        if (host_busy !== 1'b1 || dmi_resp_ready !== 1'b1 || dmi_req_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL mid_resp_state: got busy=%b resp_ready=%b valid=%b expected 1 1 0",
                     host_busy, dmi_resp_ready, dmi_req_valid);
        end
        rst = 1'b1;
        host_req = 1'b0;
        tick();
        asserts++;
        if ({host_busy, host_done, host_overrun, dmi_req_valid, dmi_resp_ready} !== 5'b0 ||
            dmi_req !== 41'd0 || host_rdata !== 32'd0 || host_status !== 2'd0) begin
            failures++;
            $display("[TB] FAIL reset_mid: got flags=%b req=%h rdata=%h status=%0d expected all 0",
                     {host_busy, host_done, host_overrun, dmi_req_valid, dmi_resp_ready},
                     dmi_req, host_rdata, host_status);
        end
        clear_script();
        rst = 1'b0;
        tick(); tick();
        exp_rdata = '0;
        asserts++;
        if (host_busy !== 1'b0 || dmi_resp_ready !== 1'b1 || host_done !== 1'b0) begin
            failures++;
            $display("[TB] FAIL post_reset_idle: got busy=%b resp_ready=%b done=%b expected 0 1 0",
                     host_busy, dmi_resp_ready, host_done);
        end
    endtask

    // Random accesses checked against an access-level model of retry/status/read-data rules.
    task automatic test_random();
        int dn, tv, td, vc, attempts, busy_seen, r;
        bit to, wr, bad;
        logic [6:0]  addr;
        logic [31:0] wd;
        logic [1:0]  codes[4];
        logic [31:0] datas[4];
        logic [1:0]  fin_code;
        logic [31:0] fin_data;
        logic [1:0]  exp_status;
        for (int it = 0; it < 24; it++) begin
            clear_script();
            wr   = 1'($urandom_range(0, 1));
            addr = 7'($urandom);
            wd   = $urandom;
            ready_delay = $urandom_range(0, 3);
            resp_lat    = $urandom_range(1, 4);
            for (int k = 0; k < 4; k++) begin
                r = $urandom_range(0, 9);
                codes[k] = (r < 4) ? 2'b11 : (r < 8) ? 2'b00 : 2'b10;
                datas[k] = $urandom;
                rq.push_back(codes[k]);
                dq.push_back(datas[k]);
            end
            attempts = 0; busy_seen = 0; fin_code = 2'b00; fin_data = '0;
            for (int k = 0; k < 4; k++) begin
                attempts++;
                if (codes[k] == 2'b11 && busy_seen < MAX_RETRY) begin
                    busy_seen++;
                end else begin
                    fin_code = codes[k];
                    fin_data = datas[k];
                    break;
                end
            end
            exp_status = (fin_code == 2'b00) ? 2'd0 : (fin_code == 2'b11) ? 2'd3 : 2'd2;
            if (!wr && fin_code == 2'b00) exp_rdata = fin_data;
            do_access(wr, addr, wd, 1, dn, tv, td, vc, to);
            asserts++;
            if (to || dn !== 1 || hs_count !== attempts) begin
                failures++;
                $display("[TB] FAIL rand_attempts[%0d]: got hs=%0d done=%0d expected %0d 1",
                         it, hs_count, dn, attempts);
            end
            asserts++;
            if (host_status !== exp_status || host_rdata !== exp_rdata) begin
                failures++;
                $display("[TB] FAIL rand_result[%0d]: got status=%0d rdata=%h expected %0d %h",
                         it, host_status, host_rdata, exp_status, exp_rdata);
            end
            bad = 1'b0;
            for (int k = 0; k < hs_payload.size(); k++) begin
                if (hs_payload[k].addr !== addr) bad = 1'b1;
                if (hs_payload[k].op !== (wr ? DTM_WRITE : DTM_READ)) bad = 1'b1;
                if (wr && hs_payload[k].data !== wd) bad = 1'b1;
            end
            asserts++;
            if (bad) begin
                failures++;
                $display("[TB] FAIL rand_payload[%0d]: got mismatching request fields, expected addr=%h wr=%b data=%h",
                         it, addr, wr, wd);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_read();
        test_level_hold();
        test_busy_retry();
        test_busy_exhausted();
        test_timeout();
        test_overrun();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
        $finish;
    end

endmodule
